equality_sweeper: RTL

Hardware self-test initiator for the combinational `equality` comparator. On `start` it drives every (a, b) operand pair of width W into the comparator, one pair at a time. For each pair it samples the returned `equal` bit and checks it against a built-in golden result. At the end it reports a pass/fail verdict, a mismatch count and the first failing pair. It sits beside the comparator on the FPGA board, so the exhaustive check runs on silicon rather than in simulation.

---
 rtl/equality_sweeper.sv | 89 ++++++++
 1 files changed

// File: rtl/equality_sweeper.sv
// equality_sweeper: exhaustive on-silicon self-test driver for an equality comparator
module equality_sweeper #(
  parameter int W = 5,
  parameter int SETTLE = 1,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  input  logic             equal,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [W-1:0]     fail_a,
  output logic [W-1:0]     fail_b,
  output logic             fail_valid
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, fa_q, fa_d, fb_q, fb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic fv_q, fv_d, sample, mism, last;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    fa_d = fa_q;
    fb_d = fb_q;
    cnt_d = cnt_q;
    err_d = err_q;
    fv_d = fv_q;
    sample = state_q == RUN && cnt_q == CW'(SETTLE - 1);
    mism = sample && (equal != (a_q == b_q));
    last = &{a_q, b_q};
    if (state_q != RUN && start) begin
      state_d = RUN;
      a_d = '0;
      b_d = '0;
      cnt_d = '0;
      err_d = '0;
      fv_d = 1'b0;
    end else if (state_q == RUN) begin
      cnt_d = sample ? '0 : cnt_q + CW'(1);
      if (mism) begin
        err_d = err_q + ERR_W'(err_q != '1);
        fa_d = fv_q ? fa_q : a_q;
        fb_d = fv_q ? fb_q : b_q;
        fv_d = 1'b1;
      end
      if (sample && last) state_d = DONE;
      else if (sample) {a_d, b_d} = {a_q, b_q} + (2 * W)'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      fa_q <= '0;
      fb_q <= '0;
      cnt_q <= '0;
      err_q <= '0;
      fv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      fa_q <= fa_d;
      fb_q <= fb_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      fv_q <= fv_d;
    end
  end
  assign a = a_q;
  assign b = b_q;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign pass = done && err_q == '0;
  assign err_count = err_q;
  assign fail_a = fa_q;
  assign fail_b = fb_q;
  assign fail_valid = fv_q;
endmodule
